// File: rtl/inst_stats_pkg.sv
// Shared constants for the instruction-statistics unit: MIPS opcode/funct
// encodings, channel numbering and the opcode-to-class helper.
package inst_stats_pkg;

  localparam logic [5:0] OP_RTYPE      = 6'h00;
  localparam logic [5:0] OP_COP0       = 6'h10;
  localparam logic [5:0] OP_J          = 6'h02;
  localparam logic [5:0] OP_JAL        = 6'h03;
  localparam logic [5:0] OP_LW         = 6'h23;
  localparam logic [5:0] OP_SW         = 6'h2B;
  localparam logic [5:0] FUNCT_SYSCALL = 6'h0C;

  localparam int CH_TC       = 0;
  localparam int CH_RET      = 1;
  localparam int CH_R        = 2;
  localparam int CH_I        = 3;
  localparam int CH_J        = 4;
  localparam int CH_LOAD     = 5;
  localparam int CH_STORE    = 6;
  localparam int CH_SYSCALL  = 7;
  localparam int CH_EXT_BASE = 8;

  typedef enum logic [1:0] {
    CLS_R = 2'd0,
    CLS_I = 2'd1,
    CLS_J = 2'd2
  } inst_class_t;

  // COP0 instructions share the R-format accounting; anything that is not
  // R or a jump is treated as an immediate-format instruction.
  function automatic inst_class_t classify(input logic [5:0] op);
    inst_class_t cls;
    cls = CLS_I;
    if (op == OP_RTYPE || op == OP_COP0) cls = CLS_R;
    else if (op == OP_J || op == OP_JAL) cls = CLS_J;
    return cls;
  endfunction

endpackage

// File: rtl/inst_stats_counter.sv
// stat_counter: one statistics channel with saturating or wrapping
// increment, synchronous clear and a sticky overflow flag.
module stat_counter #(
  parameter int CNT_W = 32,
  parameter int WRAP  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] value,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Count on inc; clr wins over a same-cycle increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      value <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      if (value == CNT_MAX) begin
        ovf   <= 1'b1;
        value <= (WRAP != 0) ? '0 : CNT_MAX;
      end else begin
        value <= value + 1'b1;
      end
    end
  end

endmodule

// File: rtl/inst_stats.sv
// inst_stats: classifies retiring MIPS instructions and counts cycles,
// instruction classes, loads, stores, syscalls and external events.
// Build option INST_STATS_SNAPSHOT_EN adds a shadow bank captured by snap;
// rd_data then reads the shadow instead of the live counters.
module inst_stats
  import inst_stats_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int NUM_EXT = 2,
  parameter int WRAP    = 0,
  localparam int NUM_CH = CH_EXT_BASE + NUM_EXT,
  localparam int SEL_W  = $clog2(NUM_CH),
  localparam int EXT_W  = (NUM_EXT > 0) ? NUM_EXT : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  input  logic              halt,
  input  logic [EXT_W-1:0]  evt_ext,
  input  logic              clr,
  input  logic              snap,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] ovf,
  output logic [CNT_W-1:0]  stat_tc,
  output logic [CNT_W-1:0]  stat_r,
  output logic [CNT_W-1:0]  stat_i,
  output logic [CNT_W-1:0]  stat_j
);

  logic [NUM_CH-1:0] inc;
  logic [CNT_W-1:0]  live [NUM_CH];
  logic [CNT_W-1:0]  rd_src [NUM_CH];
  inst_class_t       cls;

  // Per-channel increment strobes; halt gates every channel.
  always_comb begin
    inc = '0;
    cls = classify(op);
    if (!halt) begin
      inc[CH_TC] = 1'b1;
      if (valid) begin
        inc[CH_RET]     = 1'b1;
        inc[CH_R]       = (cls == CLS_R);
        inc[CH_I]       = (cls == CLS_I);
        inc[CH_J]       = (cls == CLS_J);
        inc[CH_LOAD]    = (op == OP_LW);
        inc[CH_STORE]   = (op == OP_SW);
        inc[CH_SYSCALL] = (op == OP_RTYPE) && (funct == FUNCT_SYSCALL);
      end
      for (int k = 0; k < NUM_EXT; k++) inc[CH_EXT_BASE+k] = evt_ext[k];
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    stat_counter #(
      .CNT_W (CNT_W),
      .WRAP  (WRAP)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (inc[ch]),
      .clr   (clr),
      .value (live[ch]),
      .ovf   (ovf[ch])
    );
  end

`ifdef INST_STATS_SNAPSHOT_EN
  logic [CNT_W-1:0] shadow [NUM_CH];

  // Shadow captures the pre-update live values, so clr+snap keeps pre-clear counts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int ch = 0; ch < NUM_CH; ch++) shadow[ch] <= '0;
    end else if (snap) begin
      for (int ch = 0; ch < NUM_CH; ch++) shadow[ch] <= live[ch];
    end
  end

  assign rd_src = shadow;
`else
  logic unused_snap;
  assign unused_snap = snap;
  assign rd_src      = live;
`endif

  // Registered read port; out-of-range selects read as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (int'(rd_sel) < NUM_CH) begin
      rd_data <= rd_src[rd_sel];
    end else begin
      rd_data <= '0;
    end
  end

  assign stat_tc = live[CH_TC];
  assign stat_r  = live[CH_R];
  assign stat_i  = live[CH_I];
  assign stat_j  = live[CH_J];

endmodule

// File: tb/tb_inst_stats.sv
// Directed bench for inst_stats: a saturating and a wrapping 8-bit instance
// share all inputs; expected values are hand-computed constants.
module tb_inst_stats;

  localparam int CNT_W  = 8;
  localparam int NUM_CH = 10;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             valid = 1'b0;
  logic [5:0]       op = '0;
  logic [5:0]       funct = '0;
  logic             halt = 1'b0;
  logic [1:0]       evt_ext = '0;
  logic             clr = 1'b0;
  logic             snap = 1'b0;
  logic [3:0]       rd_sel = '0;

  logic [CNT_W-1:0]  s_rd, s_tc, s_r, s_i, s_j;
  logic [NUM_CH-1:0] s_ovf;
  logic [CNT_W-1:0]  w_rd, w_tc, w_r, w_i, w_j;
  logic [NUM_CH-1:0] w_ovf;

  int errors = 0;
  int checks = 0;

  inst_stats #(.CNT_W(CNT_W), .NUM_EXT(2), .WRAP(0)) u_sat (
    .clk(clk), .reset(reset), .valid(valid), .op(op), .funct(funct),
    .halt(halt), .evt_ext(evt_ext), .clr(clr), .snap(snap), .rd_sel(rd_sel),
    .rd_data(s_rd), .ovf(s_ovf), .stat_tc(s_tc), .stat_r(s_r),
    .stat_i(s_i), .stat_j(s_j)
  );

  inst_stats #(.CNT_W(CNT_W), .NUM_EXT(2), .WRAP(1)) u_wrap (
    .clk(clk), .reset(reset), .valid(valid), .op(op), .funct(funct),
    .halt(halt), .evt_ext(evt_ext), .clr(clr), .snap(snap), .rd_sel(rd_sel),
    .rd_data(w_rd), .ovf(w_ovf), .stat_tc(w_tc), .stat_r(w_r),
    .stat_i(w_i), .stat_j(w_j)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic read_ch(input logic [3:0] sel, input logic [31:0] exp, input string tag);
    rd_sel = sel;
    tick();
    check(tag, 32'(s_rd), exp);
  endtask

  initial begin
    // Reset held for 3 cycles
    tick(3);
    check("reset_tc", 32'(s_tc), 0);
    check("reset_ovf", 32'(s_ovf), 0);
    check("reset_rd", 32'(s_rd), 0);
    reset = 1'b1;

    // 10 idle cycles
    tick(10);
    check("idle_tc", 32'(s_tc), 10);
    check("idle_r", 32'(s_r), 0);
    check("idle_i", 32'(s_i), 0);
    check("idle_j", 32'(s_j), 0);
    check("idle_ovf", 32'(s_ovf), 0);
    halt = 1'b1;
    read_ch(4'd1, 0, "idle_ret");
    halt = 1'b0;

    // Retire add, lw, sw, j, syscall; evt_ext[0] all 5 cycles, evt_ext[1] 2 cycles
    valid = 1'b1;
    op = 6'h00; funct = 6'h20; evt_ext = 2'b11; tick();
    op = 6'h23; funct = 6'h00; evt_ext = 2'b11; tick();
    op = 6'h2B; evt_ext = 2'b01; tick();
    op = 6'h02; evt_ext = 2'b01; tick();
    op = 6'h00; funct = 6'h0C; evt_ext = 2'b01; tick();
    valid = 1'b0; evt_ext = 2'b00; funct = 6'h00;
    halt = 1'b1;
    check("seq_tc", 32'(s_tc), 15);
    check("seq_r", 32'(s_r), 2);
    check("seq_i", 32'(s_i), 2);
    check("seq_j", 32'(s_j), 1);
    snap = 1'b1; tick(); snap = 1'b0;
    read_ch(4'd1, 5, "seq_ret");
    read_ch(4'd5, 1, "seq_load");
    read_ch(4'd6, 1, "seq_store");
    read_ch(4'd7, 1, "seq_syscall");
    read_ch(4'd8, 5, "seq_ext0");
    read_ch(4'd9, 2, "seq_ext1");
    check("halt_reads_tc", 32'(s_tc), 15);

    // Halt with valid and events high: nothing moves
    valid = 1'b1; op = 6'h23; evt_ext = 2'b11;
    tick(5);
    check("halt_tc", 32'(s_tc), 15);
    check("halt_r", 32'(s_r), 2);
    check("halt_i", 32'(s_i), 2);
    check("halt_j", 32'(s_j), 1);
    halt = 1'b0; evt_ext = 2'b00;
    tick();
    check("resume_tc", 32'(s_tc), 16);
    check("resume_i", 32'(s_i), 3);
    check("resume_ovf", 32'(s_ovf), 0);
    valid = 1'b0; op = 6'h00;

    // Out-of-range select reads zero
    halt = 1'b1;
    read_ch(4'd8, 5, "sel8_a");
    read_ch(4'd10, 0, "sel_numch");
    read_ch(4'd8, 5, "sel8_b");
    read_ch(4'd15, 0, "sel15");
    halt = 1'b0;

    // clr beats the same-cycle increment
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_tc", 32'(s_tc), 0);
    check("clr_i", 32'(s_i), 0);
    check("clr_r", 32'(s_r), 0);

    // Saturate vs wrap over 260 cycles
    tick(260);
    check("sat_tc", 32'(s_tc), 255);
    check("sat_ovf", 32'(s_ovf), 1);
    check("wrap_tc", 32'(w_tc), 4);
    check("wrap_ovf", 32'(w_ovf), 1);
    check("sat_r_still0", 32'(s_r), 0);
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr2_sat_tc", 32'(s_tc), 0);
    check("clr2_sat_ovf", 32'(s_ovf), 0);
    check("clr2_wrap_tc", 32'(w_tc), 0);
    check("clr2_wrap_ovf", 32'(w_ovf), 0);

    // Snapshot at tc=20, read 10 cycles later; then clr+snap together
    tick(20);
    check("snap_pre_tc", 32'(s_tc), 20);
    snap = 1'b1; tick(); snap = 1'b0;
    tick(9);
    check("snap_run_tc", 32'(s_tc), 30);
`ifdef INST_STATS_SNAPSHOT_EN
    read_ch(4'd0, 20, "snap_rd");
`else
    read_ch(4'd0, 30, "live_rd");
`endif
    clr = 1'b1; snap = 1'b1; tick(); clr = 1'b0; snap = 1'b0;
    check("clrsnap_tc", 32'(s_tc), 0);
`ifdef INST_STATS_SNAPSHOT_EN
    read_ch(4'd0, 31, "clrsnap_rd");
`else
    read_ch(4'd0, 0, "clrsnap_live_rd");
`endif

    // Build up ovf and rd_data, then reset asynchronously between edges
    tick(260);
    check("pre_rst_ovf", 32'(s_ovf), 1);
`ifdef INST_STATS_SNAPSHOT_EN
    read_ch(4'd0, 31, "pre_rst_rd");
`else
    read_ch(4'd0, 255, "pre_rst_rd");
`endif
    #2 reset = 1'b0;
    #1;
    check("arst_tc", 32'(s_tc), 0);
    check("arst_ovf", 32'(s_ovf), 0);
    check("arst_rd", 32'(s_rd), 0);
    check("arst_wrap_tc", 32'(w_tc), 0);
    check("arst_wrap_ovf", 32'(w_ovf), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_stats.md
# inst_stats

Parametrised instruction-statistics unit for the MIPS cores; successor to the fixed four-counter statistics block on the single-cycle CPU. It classifies every retired instruction from its opcode/funct, counts cycles, instruction classes, loads, stores, syscalls and external events in NUM_CH independent counters of configurable width, and exposes them through a registered read port, optional snapshot shadow and sticky overflow flags. It sits beside the CPU top, driven by the decode-stage instruction word and the halt signal.

## Interface
- CNT_W, 32: counter width in bits (8..64).
- NUM_EXT, 2: number of external event inputs (0..8); NUM_CH = 8 + NUM_EXT.
- WRAP, 0: 0 = counters saturate at all-ones, 1 = counters wrap to zero.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid  in  1  an instruction retires this cycle.
- op  in  6  opcode of retiring instruction (inst[31:26]).
- funct  in  6  funct field of retiring instruction (inst[5:0]).
- halt  in  1  CPU halted; freezes all counting.
- evt_ext  in  NUM_EXT  external event strobes (one count per high cycle).
- clr  in  1  synchronous clear pulse: all counters and overflow flags to zero.
- snap  in  1  copy all live counters to shadow registers.
- rd_sel  in  clog2(NUM_CH)  channel to read.
- rd_data  out  CNT_W  registered read data.
- ovf  out  NUM_CH  sticky per-channel overflow flags.
- stat_tc, stat_r, stat_i, stat_j  out  CNT_W each  live channels 0, 2, 3, 4 (drop-in for the old stat outputs).

## Operation
- Channels: 0 total cycles, 1 retired, 2 R-class, 3 I-class, 4 J-class, 5 load, 6 store, 7 syscall, 8.. external evt_ext[k] at channel 8+k.
- Classification (only when valid): op 0x00 or 0x10 (COP0) -> R; op 0x02/0x03 -> J; everything else -> I. op 0x23 -> load; op 0x2B -> store; op 0x00 with funct 0x0C -> syscall (also counted as R).
- Channel 0 increments every cycle with halt low; channels 1-7 increment when valid && !halt; external channels when evt_ext[k] && !halt.
- At maximum value with increment: WRAP=0 holds all-ones, WRAP=1 goes to zero; either way ovf[ch] sets and stays set until clr or reset.
- clr overrides any same-cycle increment: counter becomes 0, ovf cleared.
- snap: shadow[ch] <= live[ch] value before this edge's update; clr+snap same cycle captures pre-clear values.
- rd_data returns shadow (snapshot build) or live value of rd_sel; rd_sel >= NUM_CH returns 0.

## Timing
- Reset: all counters, shadows, ovf, rd_data = 0; stat_* = 0.
- First cycle after reset deassert with halt low: stat_tc becomes 1 at that edge.
- Increment latency: event in cycle N visible on counter/stat_* after edge N.
- rd_data latency 1 cycle: rd_sel sampled at edge N, data valid after edge N; reflects counter value before edge N's update.
- halt asserted mid-stream: counting stops at that edge; clr, snap and reads still act during halt.
- Reset asserted mid-operation: immediate asynchronous clear of all state, no partial update.

## Configuration
- INST_STATS_SNAPSHOT_EN defined: shadow register bank built; snap captures; rd_data reads shadow.
- Undefined: no shadow bank; snap port present but ignored; rd_data reads live counters.

## Structure
- Package inst_stats_pkg: opcode constants (OP_RTYPE, OP_COP0, OP_J, OP_JAL, OP_LW, OP_SW), FUNCT_SYSCALL, channel index constants CH_TC..CH_SYSCALL, CH_EXT_BASE.
- One sub-module stat_counter (CNT_W, WRAP): inc, clr inputs; value and sticky ovf outputs; instantiated NUM_CH times by generate loop.

## Test plan
- Reset low 3 cycles then 10 cycles halt low, valid low -> stat_tc = 10, all other channels 0, ovf = 0.
- Retire sequence add (op 0,funct 0x20), lw, sw, j, syscall, one per cycle -> retired 5, R 2, I 2, J 1, load 1, store 1, syscall 1.
- CNT_W=8, WRAP=0, 260 cycles -> stat_tc = 255, ovf[0] = 1; WRAP=1 -> stat_tc = 4, ovf[0] = 1; then clr -> 0, ovf[0] = 0.
- Assert halt for 5 cycles with valid and evt_ext high -> no channel changes; deassert -> counting resumes next edge.
- With INST_STATS_SNAPSHOT_EN: snap at stat_tc=20, run 10 more cycles, read rd_sel=0 -> rd_data = 20 one cycle later; clr+snap same cycle -> shadow holds pre-clear, live = 0.
- rd_sel = NUM_CH -> rd_data = 0; reset asserted mid-count -> all outputs 0 immediately, without waiting for clk.
